// File: rtl/poly_mau_wb_pkg.sv
// poly_pkg: shared widths, writeback FSM state type and the FIFO entry
// layout used by the POLY_MAU writeback slice.
package poly_pkg;
  localparam int unsigned COEF_W = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;

  // One buffered MAU beat: o0 always valid, o1 valid only when pair=1.
  typedef struct packed {
    logic              pair;
    logic [COEF_W-1:0] o1;
    logic [COEF_W-1:0] o0;
  } wb_entry_t;
endpackage

// File: rtl/poly_mau_wb_if.sv
// poly_mau_wb_if: polynomial RAM write port (valid/ready).
//   wb_we/wb_addr/wb_wdata : write request, driven by the master
//   wb_ready               : RAM accepts the request this cycle
interface poly_mau_wb_if;
  import poly_pkg::*;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [COEF_W-1:0] wb_wdata;
  logic              wb_ready;

  modport master (output wb_we, output wb_addr, output wb_wdata, input wb_ready);
  modport slave  (input wb_we, input wb_addr, input wb_wdata, output wb_ready);
endinterface

// File: rtl/poly_wb_fifo.sv
// poly_wb_fifo: DEPTH-entry beat buffer for the writeback stage.
//   push/din   : write one entry (ignored when full unless popping)
//   pop        : drop the head entry
//   head       : current head entry; head_nx : entry behind the head
//   full/empty/count/free : occupancy status
module poly_wb_fifo
  import poly_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     head,
  output wb_entry_t     head_nx,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok, wr_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop && !empty;
  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign wr_ok  = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_ok) - CW'(pop_ok);
    end
  end

  assign head    = mem[rd_ptr];
  assign head_nx = mem[ptr_inc(rd_ptr)];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;
endmodule

// File: rtl/poly_mau.sv
// poly_mau_wb: writeback stage behind POLY_MAU.
// Buffers MAU result beats and writes them one coefficient per cycle to a
// polynomial RAM, addressed from wb_base for wb_len coefficients.
//   clk, rst            : clock, synchronous active-high reset
//   wb_start/base/len/dual : transfer setup, accepted only when idle
//   poly_q              : modulus for the optional range check
//   poly_valid, poly_mau_o0/o1 : MAU result beat
//   wb_stall            : throttle request towards the MAU
//   ram                 : RAM write port (poly_mau_wb_if.master)
//   wb_busy, wb_done    : transfer status, done is a one-cycle pulse
//   err_ovf/unexp/range : sticky error flags
// Optional feature macro: POLY_WB_RANGE_CHK_EN (flag written data >= poly_q).
module poly_mau_wb
  import poly_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_start,
  input  logic [ADDR_W-1:0] wb_base,
  input  logic [LEN_W-1:0]  wb_len,
  input  logic              wb_dual,
  input  logic [COEF_W-1:0] poly_q,
  input  logic              poly_valid,
  input  logic [COEF_W-1:0] poly_mau_o0,
  input  logic [COEF_W-1:0] poly_mau_o1,
  output logic              wb_stall,
  poly_mau_wb_if.master     ram,
  output logic              wb_busy,
  output logic              wb_done,
  output logic              err_ovf,
  output logic              err_unexp,
  output logic              err_range
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned FW = CW + 1;

  wb_state_t         state;
  logic              dual_q, we_q, phase_q, stall_q, busy_q, done_q, ovf_q, unexp_q;
  logic [ADDR_W-1:0] nxt_addr, addr_q;
  logic [COEF_W-1:0] wdata_q, ld_data;
  logic [LEN_W-1:0]  wr_remain, in_remain, len_eff, in_dec;
  wb_entry_t         push_ent, head, head_nx;
  logic              full, empty;
  logic [CW-1:0]     count, free;
  logic [FW-1:0]     free_nxt;
  logic              start_ok, want_push, push_ok, stray, ovf_hit;
  logic              accept, head_last, pop, ld, ld_o1;
  logic              unused_nx;

  assign start_ok  = (state == IDLE) && wb_start;
  assign len_eff   = (wb_len == '0) ? LEN_W'(256) : wb_len;
  assign want_push = poly_valid && (state == RUN) && (in_remain != '0);
  assign stray     = poly_valid && !want_push;
  assign accept    = we_q && ram.wb_ready;
  // The head entry stays in the buffer until its last coefficient is accepted.
  assign head_last = !head.pair || phase_q;
  assign pop       = accept && head_last;
  assign push_ok   = want_push && (!full || pop);
  assign ovf_hit   = want_push && full && !pop;
  assign in_dec    = (dual_q && in_remain > LEN_W'(1)) ? LEN_W'(2) : LEN_W'(1);
  assign free_nxt  = FW'(free) + FW'(pop) - FW'(push_ok);

  // o1 of the final dual beat is dropped when only one coefficient remains.
  assign push_ent.pair = dual_q && (in_remain > LEN_W'(1));
  assign push_ent.o1   = poly_mau_o1;
  assign push_ent.o0   = poly_mau_o0;
  assign unused_nx     = ^{head_nx.pair, head_nx.o1};

  poly_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_ok),
    .din     (push_ent),
    .pop     (pop),
    .head    (head),
    .head_nx (head_nx),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .free    (free)
  );

  // Output stage reload: second half of the head pair, else the entry behind
  // the head (read ahead so back-to-back entries keep one write per cycle),
  // else a fresh head when the stage is idle.
  always_comb begin
    ld      = 1'b0;
    ld_o1   = 1'b0;
    ld_data = head.o0;
    if (state == RUN) begin
      if (accept && !head_last) begin
        ld      = 1'b1;
        ld_o1   = 1'b1;
        ld_data = head.o1;
      end else if (accept) begin
        if (count >= CW'(2)) begin
          ld      = 1'b1;
          ld_data = head_nx.o0;
        end
      end else if (!we_q && !empty) begin
        ld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dual_q    <= 1'b0;
      nxt_addr  <= '0;
      wr_remain <= '0;
      in_remain <= '0;
      we_q      <= 1'b0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      stall_q <= (free_nxt <= FW'(SKID));
      case (state)
        IDLE: if (wb_start) begin
          state     <= RUN;
          busy_q    <= 1'b1;
          dual_q    <= wb_dual;
          nxt_addr  <= wb_base;
          wr_remain <= len_eff;
          in_remain <= len_eff;
          ovf_q     <= 1'b0;
          unexp_q   <= 1'b0;
        end
        RUN: begin
          if (push_ok) in_remain <= in_remain - in_dec;
          if (accept) begin
            wr_remain <= wr_remain - LEN_W'(1);
            if (wr_remain == LEN_W'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (ld) begin
        we_q     <= 1'b1;
        addr_q   <= nxt_addr;
        nxt_addr <= nxt_addr + ADDR_W'(1);
        wdata_q  <= ld_data;
        phase_q  <= ld_o1;
      end else if (accept) begin
        we_q <= 1'b0;
      end
      if (stray)   unexp_q <= 1'b1;
      if (ovf_hit) ovf_q   <= 1'b1;
    end
  end

`ifdef POLY_WB_RANGE_CHK_EN
  logic range_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) range_q <= 1'b0;
    else if (accept && (wdata_q >= poly_q)) range_q <= 1'b1;
  end
  assign err_range = range_q;
`else
  logic unused_q;
  assign unused_q  = ^{poly_q, start_ok};
  assign err_range = 1'b0;
`endif

  assign ram.wb_we    = we_q;
  assign ram.wb_addr  = addr_q;
  assign ram.wb_wdata = wdata_q;
  assign wb_stall     = stall_q;
  assign wb_busy      = busy_q;
  assign wb_done      = done_q;
  assign err_ovf      = ovf_q;
  assign err_unexp    = unexp_q;
endmodule

// File: tb/tb_poly_mau_wb.sv
module tb_poly_mau_wb;
  import poly_pkg::*;

`ifdef POLY_WB_RANGE_CHK_EN
  localparam bit RNG_EN = 1'b1;
`else
  localparam bit RNG_EN = 1'b0;
`endif
  localparam logic [23:0] Q = 24'd3329;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wb_start, wb_dual, poly_valid;
  logic [7:0]  wb_base;
  logic [8:0]  wb_len;
  logic [23:0] poly_q, o0, o1;
  logic        wb_stall, wb_busy, wb_done, err_ovf, err_unexp, err_range;

  poly_mau_wb_if ram ();

  poly_mau_wb #(.DEPTH(8), .SKID(4)) dut (
    .clk(clk), .rst(rst), .wb_start(wb_start), .wb_base(wb_base), .wb_len(wb_len),
    .wb_dual(wb_dual), .poly_q(poly_q), .poly_valid(poly_valid),
    .poly_mau_o0(o0), .poly_mau_o1(o1), .wb_stall(wb_stall), .ram(ram),
    .wb_busy(wb_busy), .wb_done(wb_done), .err_ovf(err_ovf),
    .err_unexp(err_unexp), .err_range(err_range)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard of expected RAM writes, consumed by the write monitor.
  typedef struct packed { logic [7:0] a; logic [23:0] d; } wr_t;
  wr_t exp_q[$];
  int  wr_cnt = 0, done_cnt = 0;
  bit  acc_prev_last = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (wb_done) begin
      done_cnt++;
      chk("done_after_last_write", 32'(acc_prev_last), 1);
    end
    acc_prev_last = 1'b0;
    if (ram.wb_we && ram.wb_ready) begin
      wr_cnt++;
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", ram.wb_addr, e.a);
        chk("wr_data", ram.wb_wdata, e.d);
        acc_prev_last = (exp_q.size() == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; poly_valid = 1'b0; wb_start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete(); wr_cnt = 0; done_cnt = 0; acc_prev_last = 1'b0;
  endtask

  task automatic start(input logic [7:0] b, input logic [8:0] l, input logic d);
    wb_start = 1'b1; wb_base = b; wb_len = l; wb_dual = d;
    tick();
    wb_start = 1'b0;
  endtask

  task automatic beat(input logic [23:0] d0, input logic [23:0] d1);
    poly_valid = 1'b1; o0 = d0; o1 = d1;
    tick();
    poly_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (wb_done !== 1'b1 && n < maxc);
    chk("done_seen", wb_done, 1);
    chk("busy_with_done", wb_busy, 1);
    @(negedge clk);
    chk("done_one_cycle", wb_done, 0);
    chk("busy_after_done", wb_busy, 0);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [7:0]       base;
    logic [8:0]       len;
    logic             dual;
    logic [3:0]       nb;
    logic [5:0][23:0] b0;
    logic [5:0][23:0] b1;
    logic [3:0]       ne;
    logic [5:0][7:0]  ea;
    logic [5:0][23:0] ed;
  } vec_t;
  vec_t vt[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_start = 1'b0; wb_base = '0; wb_len = '0; wb_dual = 1'b0;
    poly_q = Q; poly_valid = 1'b0; o0 = '0; o1 = '0; ram.wb_ready = 1'b0;

    // Packed arrays: element 0 is the rightmost field of each concatenation.
    vt[0] = '0; vt[0].base = 8'h10; vt[0].len = 9'd6; vt[0].dual = 1'b0; vt[0].nb = 4'd6;
    vt[0].b0 = {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
    vt[0].ne = 4'd6; vt[0].ea = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    vt[0].ed = {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
    vt[1] = '0; vt[1].base = 8'hFE; vt[1].len = 9'd4; vt[1].dual = 1'b1; vt[1].nb = 4'd2;
    vt[1].b0 = {96'd0, 24'd9, 24'd7}; vt[1].b1 = {96'd0, 24'd10, 24'd8};
    vt[1].ne = 4'd4; vt[1].ea = {16'h0, 8'h01, 8'h00, 8'hFF, 8'hFE};
    vt[1].ed = {48'd0, 24'd10, 24'd9, 24'd8, 24'd7};
    vt[2] = '0; vt[2].base = 8'h20; vt[2].len = 9'd3; vt[2].dual = 1'b1; vt[2].nb = 4'd2;
    vt[2].b0 = {96'd0, 24'd3, 24'd1}; vt[2].b1 = {96'd0, 24'd4, 24'd2};
    vt[2].ne = 4'd3; vt[2].ea = {24'h0, 8'h22, 8'h21, 8'h20};
    vt[2].ed = {72'd0, 24'd3, 24'd2, 24'd1};
    vt[3] = '0; vt[3].base = 8'hFF; vt[3].len = 9'd2; vt[3].dual = 1'b0; vt[3].nb = 4'd2;
    vt[3].b0 = {96'd0, 24'hCFF, 24'hC00};
    vt[3].ne = 4'd2; vt[3].ea = {32'h0, 8'h00, 8'hFF};
    vt[3].ed = {96'd0, 24'hCFF, 24'hC00};

    do_reset();
    chk("rst_we", ram.wb_we, 0);      chk("rst_addr", ram.wb_addr, 0);
    chk("rst_wdata", ram.wb_wdata, 0); chk("rst_stall", wb_stall, 0);
    chk("rst_busy", wb_busy, 0);      chk("rst_done", wb_done, 0);
    chk("rst_errs", {err_ovf, err_unexp, err_range}, 0);

    // Table-driven transfers with full-rate source and sink.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      ram.wb_ready = 1'b1;
      for (int k = 0; k < int'(vt[v].ne); k++) exp_q.push_back({vt[v].ea[k], vt[v].ed[k]});
      start(vt[v].base, vt[v].len, vt[v].dual);
      for (int k = 0; k < int'(vt[v].nb); k++) beat(vt[v].b0[k], vt[v].b1[k]);
      wait_done(40);
      repeat (3) tick();
      chk("vec_writes", wr_cnt, 32'(vt[v].ne));
      chk("vec_done_cnt", done_cnt, 1);
      chk("vec_pending", exp_q.size(), 0);
      chk("vec_errs", {err_ovf, err_unexp, err_range}, 0);
    end

    // Backpressure: stall threshold, first-write latency, hold, overflow.
    do_reset();
    ram.wb_ready = 1'b0;
    start(8'h40, 9'd9, 1'b0);
    for (int k = 0; k < 8; k++) begin
      beat(24'h100 + 24'(k), 24'h0);
      chk("bp_stall", wb_stall, 32'((8 - (k + 1)) <= 4));
      chk("bp_we_latency", ram.wb_we, 32'(k >= 1));
      if (k >= 1) begin
        chk("bp_hold_addr", ram.wb_addr, 8'h40);
        chk("bp_hold_data", ram.wb_wdata, 24'h100);
      end
    end
    chk("bp_no_ovf_yet", err_ovf, 0);
    beat(24'h1FF, 24'h0);
    chk("bp_ovf", err_ovf, 1);
    chk("bp_no_unexp", err_unexp, 0);
    repeat (3) tick();
    chk("bp_hold_addr2", ram.wb_addr, 8'h40);
    chk("bp_hold_data2", ram.wb_wdata, 24'h100);
    for (int k = 0; k < 8; k++) exp_q.push_back({8'h40 + 8'(k), 24'h100 + 24'(k)});
    exp_q.push_back({8'h48, 24'h200});
    ram.wb_ready = 1'b1;
    repeat (3) tick();
    beat(24'h200, 24'h0);
    wait_done(60);
    chk("bp_writes", wr_cnt, 9);
    chk("bp_ovf_sticky", err_ovf, 1);

    // Stray beats, and wb_start while busy.
    do_reset();
    ram.wb_ready = 1'b1;
    beat(24'd5, 24'd6);
    chk("idle_unexp", err_unexp, 1);
    start(8'h30, 9'd3, 1'b0);
    chk("start_clears_unexp", err_unexp, 0);
    for (int k = 0; k < 3; k++) exp_q.push_back({8'h30 + 8'(k), 24'h11 + 24'(k)});
    for (int k = 0; k < 4; k++) beat(24'h11 + 24'(k), 24'h0);
    chk("extra_beat_unexp", err_unexp, 1);
    wb_start = 1'b1; wb_base = 8'h99; wb_len = 9'd1;
    tick();
    wb_start = 1'b0;
    chk("busy_start_ignored", err_unexp, 1);
    wait_done(20);
    repeat (3) tick();
    chk("stray_writes", wr_cnt, 3);
    chk("stray_done_cnt", done_cnt, 1);

    // Reset in the middle of a transfer.
    do_reset();
    ram.wb_ready = 1'b0;
    start(8'h50, 9'd5, 1'b0);
    for (int k = 0; k < 3; k++) beat(24'h40 + 24'(k), 24'h0);
    tick();
    chk("pre_rst_we", ram.wb_we, 1);
    chk("pre_rst_busy", wb_busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_we", ram.wb_we, 0);     chk("mid_rst_addr", ram.wb_addr, 0);
    chk("mid_rst_wdata", ram.wb_wdata, 0); chk("mid_rst_busy", wb_busy, 0);
    chk("mid_rst_stall", wb_stall, 0);
    ram.wb_ready = 1'b1;
    repeat (20) tick();
    chk("mid_rst_no_writes", wr_cnt, 0);
    chk("mid_rst_no_done", done_cnt, 0);
    exp_q.push_back({8'h70, 24'h33});
    start(8'h70, 9'd1, 1'b0);
    beat(24'h33, 24'h0);
    wait_done(20);
    chk("post_rst_writes", wr_cnt, 1);

    // Range check at write acceptance.
    do_reset();
    ram.wb_ready = 1'b1;
    exp_q.push_back({8'h60, 24'd3328});
    exp_q.push_back({8'h61, 24'd3329});
    start(8'h60, 9'd2, 1'b0);
    beat(24'd3328, 24'h0);
    repeat (3) tick();
    chk("range_below_q", err_range, 0);
    beat(24'd3329, 24'h0);
    wait_done(20);
    chk("range_at_q", err_range, 32'(RNG_EN));
    chk("range_writes", wr_cnt, 2);

    // Randomised transfers against a coefficient-stream model.
    for (int t = 0; t < 8; t++) begin
      logic [7:0] base;
      logic [8:0] lenv;
      logic       dual;
      int         len_n, rem, wi, rpct, vpct, n;
      bit         rng;
      logic [23:0] d0, d1;
      do_reset();
      base = 8'($urandom);
      lenv = (t == 0) ? 9'd0 : (t == 1) ? 9'd1 : 9'($urandom_range(2, 40));
      dual = 1'($urandom);
      len_n = (lenv == 0) ? 256 : int'(lenv);
      rpct = $urandom_range(30, 100);
      vpct = $urandom_range(30, 100);
      rem = len_n; wi = 0; rng = 1'b0; n = 0;
      start(base, lenv, dual);
      while (done_cnt == 0 && n < 3000) begin
        ram.wb_ready = ($urandom_range(1, 100) <= rpct);
        if (rem > 0 && !wb_stall && $urandom_range(1, 100) <= vpct) begin
          d0 = 24'($urandom_range(0, 4095));
          d1 = 24'($urandom_range(0, 4095));
          poly_valid = 1'b1; o0 = d0; o1 = d1;
          exp_q.push_back({8'(base + 8'(wi)), d0}); wi++; rem--;
          if (d0 >= Q) rng = 1'b1;
          if (dual && rem > 0) begin
            exp_q.push_back({8'(base + 8'(wi)), d1}); wi++; rem--;
            if (d1 >= Q) rng = 1'b1;
          end
        end else begin
          poly_valid = 1'b0;
        end
        tick();
        n++;
      end
      poly_valid = 1'b0;
      repeat (3) tick();
      chk("rand_done_cnt", done_cnt, 1);
      chk("rand_writes", wr_cnt, len_n);
      chk("rand_pending", exp_q.size(), 0);
      chk("rand_ovf", err_ovf, 0);
      chk("rand_unexp", err_unexp, 0);
      chk("rand_range", err_range, 32'(RNG_EN & rng));
      chk("rand_busy", wb_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
